// File: rtl/frogger_pkg.sv
// Shared types and playfield constants for the frog hopper game block.
package frogger_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOP   = 3'd1,
    DYING = 3'd2,
    WIN   = 3'd3,
    OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam int GRID_STEP     = 32;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int SPAWN_X       = 304;
  localparam int SPAWN_Y       = 448;
  localparam int GOAL_Y        = 15;

  // Same-cycle presses resolve up > down > left > right.
  function automatic dir_t pick_dir(input logic up, input logic down, input logic left);
    if (up) begin
      return UP;
    end else if (down) begin
      return DOWN;
    end else if (left) begin
      return LEFT;
    end
    return RIGHT;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Loadable down-counter stepped by frame ticks; done flags the tick that empties it.
module frame_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = tick && (count_reg == W'(1));

endmodule

// File: rtl/frog_hopper.sv
// Frog sprite controller: grid hops, one-deep move queue, platform drift,
// death/respawn timing, lives and goal detection.
module frog_hopper
  import frogger_pkg::*;
#(
  parameter int STEP         = GRID_STEP,
  parameter int HOP_FRAMES   = 4,
  parameter int FROG_SIZE    = 32,
  parameter int SCREEN_W     = SCREEN_WIDTH,
  parameter int SCREEN_H     = SCREEN_HEIGHT,
  parameter int START_X      = SPAWN_X,
  parameter int START_Y      = SPAWN_Y,
  parameter int END_Y        = GOAL_Y,
  parameter int LIVES        = 3,
  parameter int LIVES_W      = $clog2(LIVES + 1),
  parameter int DEATH_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               restart,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               collision,
  input  logic               carry_en,
  input  logic [3:0]         carry_dx,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output logic [1:0]         facing,
  output logic               hopping,
  output logic               dying,
  output logic               reached_end,
  output logic               game_over,
  output logic [LIVES_W-1:0] lives
);

  localparam int TW      = $clog2(((DEATH_FRAMES > HOP_FRAMES) ? DEATH_FRAMES : HOP_FRAMES) + 1);
  localparam int T_HOP   = 0;
  localparam int T_DEATH = 1;

  localparam logic [9:0]         HOP_D     = 10'(STEP / HOP_FRAMES);
  localparam logic [9:0]         X0        = 10'(START_X);
  localparam logic [9:0]         Y0        = 10'(START_Y);
  localparam logic [9:0]         GOAL      = 10'(END_Y);
  localparam logic signed [10:0] X_MAX     = 11'(SCREEN_W - FROG_SIZE);
  localparam logic [11:0]        STEP_W    = 12'(STEP);
  localparam logic [11:0]        MOVE_SPAN = 12'(FROG_SIZE + STEP);
  localparam logic [11:0]        LIM_W     = 12'(SCREEN_W);
  localparam logic [11:0]        LIM_H     = 12'(SCREEN_H);

  state_t             state_reg, state_next;
  logic [9:0]         pos_x_reg, pos_x_next;
  logic [9:0]         pos_y_reg, pos_y_next;
  dir_t               facing_reg, facing_next;
  dir_t               hop_dir_reg, hop_dir_next;
  dir_t               queue_dir_reg, queue_dir_next;
  logic               queue_valid_reg, queue_valid_next;
  logic [LIVES_W-1:0] lives_reg, lives_next;

  logic [1:0]         timer_load, timer_tick, timer_done;
  logic [1:0][TW-1:0] timer_value;

  for (genvar gi = 0; gi < 2; gi++) begin : g_timer
    frame_counter #(.W(TW)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (timer_load[gi]),
      .load_value (timer_value[gi]),
      .tick       (timer_tick[gi]),
      .done       (timer_done[gi])
    );
  end

  logic               tick_en, active, hop_tick, carry_tick;
  logic               btn_any, req_valid, move_ok, carry_death, death;
  dir_t               btn_dir, req_dir;
  logic [9:0]         x_hop, y_hop, x_new;
  logic signed [10:0] x_sum;

  always_comb begin
    tick_en    = enable && frame_tick;
    active     = (state_reg == IDLE) || (state_reg == HOP);
    hop_tick   = (state_reg == HOP) && tick_en;
    carry_tick = active && tick_en && carry_en;

    btn_any   = btn_up || btn_down || btn_left || btn_right;
    btn_dir   = pick_dir(btn_up, btn_down, btn_left);
    req_valid = btn_any || queue_valid_reg;
    req_dir   = btn_any ? btn_dir : queue_dir_reg;

    move_ok = 1'b0;
    case (req_dir)
      UP:      move_ok = {2'b00, pos_y_reg} >= STEP_W;
      DOWN:    move_ok = ({2'b00, pos_y_reg} + MOVE_SPAN) <= LIM_H;
      LEFT:    move_ok = {2'b00, pos_x_reg} >= STEP_W;
      default: move_ok = ({2'b00, pos_x_reg} + MOVE_SPAN) <= LIM_W;
    endcase

    x_hop = pos_x_reg;
    y_hop = pos_y_reg;
    if (hop_tick) begin
      case (hop_dir_reg)
        UP:      y_hop = pos_y_reg - HOP_D;
        DOWN:    y_hop = pos_y_reg + HOP_D;
        LEFT:    x_hop = pos_x_reg - HOP_D;
        default: x_hop = pos_x_reg + HOP_D;
      endcase
    end

    // Drift is applied on top of the hop step; leaving the playfield kills and clamps.
    x_sum       = $signed({1'b0, x_hop}) + $signed({{7{carry_dx[3]}}, carry_dx});
    x_new       = x_hop;
    carry_death = 1'b0;
    if (carry_tick) begin
      if (x_sum < 11'sd0) begin
        x_new       = '0;
        carry_death = 1'b1;
      end else if (x_sum > X_MAX) begin
        x_new       = X_MAX[9:0];
        carry_death = 1'b1;
      end else begin
        x_new = x_sum[9:0];
      end
    end

    death = enable && active && (collision || carry_death);
  end

  always_comb begin
    state_next       = state_reg;
    pos_x_next       = pos_x_reg;
    pos_y_next       = pos_y_reg;
    facing_next      = facing_reg;
    hop_dir_next     = hop_dir_reg;
    queue_dir_next   = queue_dir_reg;
    queue_valid_next = queue_valid_reg;
    lives_next       = lives_reg;
    timer_load       = '0;
    timer_value      = '0;
    timer_tick       = '0;
    timer_tick[T_HOP]   = hop_tick;
    timer_tick[T_DEATH] = (state_reg == DYING) && tick_en;

    if (restart) begin
      state_next       = IDLE;
      pos_x_next       = X0;
      pos_y_next       = Y0;
      facing_next      = UP;
      hop_dir_next     = UP;
      queue_dir_next   = UP;
      queue_valid_next = 1'b0;
      lives_next       = LIVES_W'(LIVES);
      timer_load       = 2'b11;
    end else if (!enable) begin
      queue_valid_next = 1'b0;
    end else begin
      if (active) begin
        pos_x_next = x_new;
        pos_y_next = y_hop;
      end
      case (state_reg)
        IDLE, HOP: begin
          if (death) begin
            state_next              = DYING;
            lives_next              = (lives_reg == '0) ? '0 : lives_reg - LIVES_W'(1);
            queue_valid_next        = 1'b0;
            timer_load[T_DEATH]     = 1'b1;
            timer_value[T_DEATH]    = TW'(DEATH_FRAMES);
          end else if (state_reg == HOP) begin
            if (btn_any) begin
              queue_valid_next = 1'b1;
              queue_dir_next   = btn_dir;
            end
            if (timer_done[T_HOP]) begin
              state_next = IDLE;
            end
          end else if (pos_y_reg <= GOAL) begin
            state_next = WIN;
          end else if (req_valid) begin
            facing_next      = req_dir;
            queue_valid_next = 1'b0;
            if (move_ok) begin
              state_next         = HOP;
              hop_dir_next       = req_dir;
              timer_load[T_HOP]  = 1'b1;
              timer_value[T_HOP] = TW'(HOP_FRAMES);
            end
          end
        end
        DYING: begin
          if (timer_done[T_DEATH]) begin
            if (lives_reg == '0) begin
              state_next = OVER;
            end else begin
              state_next = IDLE;
              pos_x_next = X0;
              pos_y_next = Y0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pos_x_reg       <= X0;
      pos_y_reg       <= Y0;
      facing_reg      <= UP;
      hop_dir_reg     <= UP;
      queue_dir_reg   <= UP;
      queue_valid_reg <= 1'b0;
      lives_reg       <= LIVES_W'(LIVES);
    end else begin
      state_reg       <= state_next;
      pos_x_reg       <= pos_x_next;
      pos_y_reg       <= pos_y_next;
      facing_reg      <= facing_next;
      hop_dir_reg     <= hop_dir_next;
      queue_dir_reg   <= queue_dir_next;
      queue_valid_reg <= queue_valid_next;
      lives_reg       <= lives_next;
    end
  end

  assign pos_x       = pos_x_reg;
  assign pos_y       = pos_y_reg;
  assign facing      = facing_reg;
  assign lives       = lives_reg;
  assign hopping     = (state_reg == HOP);
  assign dying       = (state_reg == DYING);
  assign reached_end = (state_reg == WIN);
  assign game_over   = (state_reg == OVER);

endmodule

// File: doc/frog_hopper.md
FROG_HOPPER -- requirements
Module: frog_hopper

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  STEP, 32, grid pitch in pixels (power of 2).
  HOP_FRAMES, 4, frame ticks per hop (power of 2, divides STEP).
  FROG_SIZE, 32, sprite edge in pixels.
  SCREEN_W / SCREEN_H, 640 / 480, playfield size.
  START_X / START_Y, 304 / 448, spawn position.
  END_Y, 15, goal line (pos_y <= END_Y means goal).
  LIVES, 3, initial lives; LIVES_W = $clog2(LIVES+1).
  DEATH_FRAMES, 30, frame ticks spent dying.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  system clock.
  reset_n  in  1  asynchronous active-low reset.
  frame_tick  in  1  one-cycle pulse per video frame.
  enable  in  1  game is in PLAYING; low freezes the block.
  restart  in  1  synchronous restart pulse.
  btn_up/btn_down/btn_left/btn_right  in  1 each  debounced one-cycle press ticks.
  collision  in  1  hazard overlap this cycle.
  carry_en  in  1  frog is on a moving platform.
  carry_dx  in  4  signed px per frame of platform drift.
  pos_x, pos_y  out  10  sprite top-left.
  facing  out  2  last requested direction (dir_t).
  hopping, dying, reached_end, game_over  out  1 each  status flags.
  lives  out  LIVES_W  remaining lives.

Function
REQ-003 FSM states SHALL be IDLE, HOP, DYING, WIN, OVER; hopping/dying/reached_end/game_over are high exactly in HOP/DYING/WIN/OVER.
REQ-004 Same-cycle buttons SHALL be prioritised up > down > left > right; facing updates on every accepted or blocked request.
REQ-005 In IDLE with enable, a request SHALL enter HOP on the next cycle only if the move stays on screen: up needs pos_y >= STEP, down needs pos_y+FROG_SIZE+STEP <= SCREEN_H, left needs pos_x >= STEP, right needs pos_x+FROG_SIZE+STEP <= SCREEN_W; a blocked request stays IDLE.
REQ-006 In HOP, each frame_tick SHALL move the position STEP/HOP_FRAMES px in the hop direction; after HOP_FRAMES ticks, state returns to IDLE with net displacement exactly STEP.
REQ-007 A request during HOP SHALL be stored in a one-deep queue (a newer request overwrites it); in IDLE a valid queue entry is treated as a request and cleared.
REQ-008 On frame_tick in IDLE or HOP with carry_en, pos_x SHALL add sign-extended carry_dx in 11-bit signed arithmetic; a result outside [0, SCREEN_W-FROG_SIZE] is a death event, and pos_x clamps.
REQ-009 collision or a carry death in IDLE/HOP with enable SHALL enter DYING next cycle, decrement lives (saturating at 0), and clear the queue.
REQ-010 DYING SHALL last DEATH_FRAMES frame ticks, then go to OVER if lives==0, else respawn at START_X/START_Y in IDLE.
REQ-011 IDLE with pos_y <= END_Y SHALL enter WIN; WIN and OVER hold until restart.
REQ-012 Precedence SHALL be restart > death > hop completion > goal detect > new request.
REQ-013 restart SHALL restore the reset values below, in any state, on the next cycle.
REQ-014 enable low SHALL freeze position, timers and state, ignore buttons and carry, and clear the queue.

Reset
REQ-015 reset_n low SHALL asynchronously set state IDLE, pos=START_X/START_Y, facing=UP, lives=LIVES, queue empty, timers 0, all flags 0.

Structure
REQ-016 Package frogger_pkg SHALL hold state_t, dir_t (UP=0, DOWN=1, LEFT=2, RIGHT=3), and the screen constants.
REQ-017 A sub-module frame_counter (down-counter decremented on frame_tick, load and done ports) SHALL implement the hop and death timers.

Verification
REQ-018 Reset, enable=1, btn_up, 4 frame ticks -> pos_y steps 440,432,424,416; hopping low after the 4th tick.
REQ-019 pos_x=0, btn_left -> no hop, facing=LEFT, pos_x remains 0.
REQ-020 btn_right during HOP, then btn_up in the same hop -> after completion an up-hop starts; right is discarded.
REQ-021 carry_en=1, carry_dx=-3, pos_x=2, frame_tick -> pos_x=0, DYING, lives 3->2; after 30 ticks -> respawn at (304,448).
REQ-022 Three collisions -> lives=0, OVER after DEATH_FRAMES, game_over=1; restart -> lives=3, IDLE.
REQ-023 collision and the final hop tick in the same cycle -> DYING, no goal; hop into pos_y=0 with no collision -> WIN, reached_end=1.
